// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one mul/div op through the pipelined multiplier or the signed/unsigned
// AXI-stream dividers, holds the registered result until taken, and drains dividers on flush.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [6:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        mul_signed,
    output logic [32:0] mul_x,
    output logic [32:0] mul_y,
    input  logic [65:0] mul_z,
    output logic        div_s_valid,
    output logic        div_u_valid,
    input  logic        div_s_ready,
    input  logic        div_u_ready,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_s_dout_valid,
    input  logic        div_u_dout_valid,
    input  logic [63:0] div_s_dout,
    input  logic [63:0] div_u_dout
);
    localparam int CW = $clog2(MUL_LAT + 1);
    typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_SEND, DIV_WAIT, DRAIN, DONE} state_t;
    state_t r_state, w_next;
    logic [6:0]    r_op;
    logic [31:0]   r_src1, r_src2, r_result;
    logic [CW-1:0] r_cnt;
    logic [6:0]    w_op_1h;
    logic          w_is_mul, w_div_u, w_hs, w_dout_v, w_accept, w_cap;
    logic [63:0]   w_dout;
    logic [31:0]   w_cap_val;
    // isolate the lowest set bit so a multi-hot op resolves to one unit
    assign w_op_1h  = req_op & (~req_op + 7'd1);
    assign w_is_mul = |w_op_1h[2:0];
    assign w_div_u  = r_op[4] | r_op[6];
    assign w_hs     = (r_state == DIV_SEND) && (w_div_u ? div_u_ready : div_s_ready);
    assign w_dout_v = w_div_u ? div_u_dout_valid : div_s_dout_valid;
    assign w_dout   = w_div_u ? div_u_dout : div_s_dout;
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_cap     = 1'b0;
        w_cap_val = '0;
        case (r_state)
            IDLE: if (req_valid && req_op != 7'd0 && !flush) begin
                w_accept = 1'b1;
                w_next   = w_is_mul ? MUL_WAIT : DIV_SEND;
            end
            MUL_WAIT: if (flush) w_next = IDLE;
            else if (r_cnt == CW'(1)) begin
                w_cap     = 1'b1;
                w_cap_val = r_op[0] ? mul_z[31:0] : mul_z[63:32];
                w_next    = DONE;
            end
            DIV_SEND: if (w_hs) w_next = flush ? DRAIN : DIV_WAIT;
            else if (flush) w_next = IDLE;
            DIV_WAIT: if (w_dout_v) begin
                w_cap     = !flush;
                w_cap_val = (r_op[3] | r_op[4]) ? w_dout[63:32] : w_dout[31:0];
                w_next    = flush ? IDLE : DONE;
            end else if (flush) w_next = DRAIN;
            DRAIN: if (w_dout_v) w_next = IDLE;
            DONE: if (flush || out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op     <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= w_op_1h;
                r_src1 <= req_src1;
                r_src2 <= req_src2;
                r_cnt  <= CW'(MUL_LAT);
            end else if (r_state == MUL_WAIT) r_cnt <= r_cnt - CW'(1);
            if (w_cap) r_result <= w_cap_val;
        end
    end
    assign busy         = r_state != IDLE;
    assign done         = r_state == DONE;
    assign result       = r_result;
    assign mul_signed   = r_op[0] | r_op[1];
    assign mul_x        = {mul_signed & r_src1[31], r_src1};
    assign mul_y        = {mul_signed & r_src2[31], r_src2};
    assign div_s_valid  = (r_state == DIV_SEND) && !w_div_u;
    assign div_u_valid  = (r_state == DIV_SEND) && w_div_u;
    assign div_dividend = r_src1;
    assign div_divisor  = r_src2;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed scenarios for muldiv_ctrl with a combinational multiplier
// and hand-driven divider handshakes.
module tb_muldiv_ctrl;
    logic        clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [6:0]  req_op = '0;
    logic [31:0] req_src1 = '0, req_src2 = '0;
    logic        busy, done, mul_signed, div_s_valid, div_u_valid;
    logic [31:0] result, div_dividend, div_divisor;
    logic [32:0] mul_x, mul_y;
    logic [65:0] mul_z;
    logic        div_s_ready = 1'b0, div_u_ready = 1'b0, div_s_dout_valid = 1'b0, div_u_dout_valid = 1'b0;
    logic [63:0] div_s_dout = '0, div_u_dout = '0;
    int checks = 0, errors = 0, hs_s = 0, hs_u = 0;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush), .out_ready(out_ready),
        .busy(busy), .done(done), .result(result), .mul_signed(mul_signed),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .div_s_valid(div_s_valid), .div_u_valid(div_u_valid),
        .div_s_ready(div_s_ready), .div_u_ready(div_u_ready),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_s_dout_valid(div_s_dout_valid), .div_u_dout_valid(div_u_dout_valid),
        .div_s_dout(div_s_dout), .div_u_dout(div_u_dout)
    );

    always #5 clk = ~clk;
    assign mul_z = 66'($signed(mul_x)) * 66'($signed(mul_y));

    always @(posedge clk) begin
        if (div_s_valid && div_s_ready) hs_s <= hs_s + 1;
        if (div_u_valid && div_u_ready) hs_u <= hs_u + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        tick();
        req_valid = 1'b0; req_op = '0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if ({div_s_valid, div_u_valid, mul_signed} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {div_s_valid, div_u_valid, mul_signed}); end
        checks++; if ({mul_x, mul_y} !== 66'h0) begin errors++; $display("FAIL reset_mul_ops: got %h want 0", {mul_x, mul_y}); end
        checks++; if ({div_dividend, div_divisor} !== 64'h0) begin errors++; $display("FAIL reset_div_ops: got %h want 0", {div_dividend, div_divisor}); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        logic [6:0]  ops [4] = '{7'h01, 7'h02, 7'h04, 7'h05};
        logic [31:0] exp [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
        logic [32:0] ex  [4] = '{33'h1FFFFFFFF, 33'h1FFFFFFFF, 33'h0FFFFFFFF, 33'h1FFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 32'hFFFFFFFF, 32'h2);
            checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL mul%0d_accept busy/done: got %b want 10", i, {busy, done}); end
            checks++; if (mul_x !== ex[i]) begin errors++; $display("FAIL mul%0d_x: got %h want %h", i, mul_x, ex[i]); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul%0d_early_done: got %b want 0", i, done); end
            tick();
            checks++; if (done !== 1'b1 || result !== exp[i]) begin errors++; $display("FAIL mul%0d_result: got done=%b %h want 1 %h", i, done, result, exp[i]); end
            take();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul%0d_idle: got busy=%b want 0", i, busy); end
        end
        issue(7'h00, 32'h5, 32'h6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_op_ignored: got busy=%b want 0", busy); end
    endtask

    task automatic test_div();
        logic [6:0]  ops  [3] = '{7'h08, 7'h20, 7'h10};
        logic [31:0] a    [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7};
        logic        u    [3] = '{1'b0, 1'b0, 1'b1};
        logic [63:0] dout [3] = '{64'hFFFFFFFD_FFFFFFFF, 64'hFFFFFFFD_FFFFFFFF, 64'h00000003_00000001};
        logic [31:0] exp  [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000003};
        int hs0s, hs0u;
        for (int i = 0; i < 3; i++) begin
            hs0s = hs_s; hs0u = hs_u;
            issue(ops[i], a[i], 32'h2);
            repeat (3) tick();
            checks++; if ({div_s_valid, div_u_valid} !== {!u[i], u[i]}) begin errors++; $display("FAIL div%0d_valid_port: got %b want %b", i, {div_s_valid, div_u_valid}, {!u[i], u[i]}); end
            div_s_ready = 1'b1; div_u_ready = 1'b1;
            tick();
            div_s_ready = 1'b0; div_u_ready = 1'b0;
            checks++; if ({div_s_valid, div_u_valid, busy} !== 3'b001) begin errors++; $display("FAIL div%0d_valid_drop: got %b want 001", i, {div_s_valid, div_u_valid, busy}); end
            checks++; if ({div_dividend, div_divisor} !== {a[i], 32'h2}) begin errors++; $display("FAIL div%0d_operands: got %h want %h", i, {div_dividend, div_divisor}, {a[i], 32'h2}); end
            if (u[i]) begin div_s_dout_valid = 1'b1; div_s_dout = 64'hAAAAAAAA_55555555; end
            else begin div_u_dout_valid = 1'b1; div_u_dout = 64'hAAAAAAAA_55555555; end
            tick();
            div_s_dout_valid = 1'b0; div_u_dout_valid = 1'b0;
            repeat (3) tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL div%0d_early_done: got %b want 0", i, done); end
            if (u[i]) begin div_u_dout_valid = 1'b1; div_u_dout = dout[i]; end
            else begin div_s_dout_valid = 1'b1; div_s_dout = dout[i]; end
            tick();
            div_s_dout_valid = 1'b0; div_u_dout_valid = 1'b0;
            checks++; if (done !== 1'b1 || result !== exp[i]) begin errors++; $display("FAIL div%0d_result: got done=%b %h want 1 %h", i, done, result, exp[i]); end
            checks++; if ((hs_s - hs0s) !== int'(!u[i]) || (hs_u - hs0u) !== int'(u[i])) begin errors++; $display("FAIL div%0d_handshakes: got s=%0d u=%0d want s=%0d u=%0d", i, hs_s - hs0s, hs_u - hs0u, !u[i], u[i]); end
            take();
        end
    endtask

    task automatic test_back_to_back();
        issue(7'h01, 32'h3, 32'h5);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (done !== 1'b1 || result !== 32'hF) begin errors++; $display("FAIL hold%0d: got done=%b %h want 1 0000000f", i, done, result); end
            tick();
        end
        out_ready = 1'b1;
        req_valid = 1'b1; req_op = 7'h04; req_src1 = 32'hFFFFFFFF; req_src2 = 32'h2;
        tick();
        out_ready = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b want 00", {busy, done}); end
        tick();
        req_valid = 1'b0; req_op = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        tick(); tick();
        checks++; if (done !== 1'b1 || result !== 32'h1) begin errors++; $display("FAIL b2b_result: got done=%b %h want 1 00000001", done, result); end
        take();
    endtask

    task automatic test_flush_div();
        int hs0 = hs_s;
        issue(7'h08, 32'd20, 32'd3);
        div_s_ready = 1'b1; tick(); div_s_ready = 1'b0;
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL drain_enter: got %b want 10", {busy, done}); end
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL drain_hold: got %b want 10", {busy, done}); end
        div_s_dout_valid = 1'b1; div_s_dout = 64'hBAD0BAD0_11111111;
        tick();
        div_s_dout_valid = 1'b0;
        checks++; if ({busy, done} !== 2'b00 || (hs_s - hs0) !== 1) begin errors++; $display("FAIL drain_exit: got %b hs=%0d want 00 hs=1", {busy, done}, hs_s - hs0); end
        issue(7'h08, 32'd20, 32'd3);
        div_s_ready = 1'b1; tick(); div_s_ready = 1'b0;
        div_s_dout_valid = 1'b1; div_s_dout = 64'h00000006_00000002;
        tick();
        div_s_dout_valid = 1'b0;
        checks++; if (done !== 1'b1 || result !== 32'h6) begin errors++; $display("FAIL post_drain_result: got done=%b %h want 1 00000006", done, result); end
        take();
        issue(7'h08, 32'd20, 32'd3);
        div_s_ready = 1'b1; tick(); div_s_ready = 1'b0;
        flush = 1'b1; div_s_dout_valid = 1'b1; div_s_dout = 64'h00000009_00000009;
        tick();
        flush = 1'b0; div_s_dout_valid = 1'b0;
        checks++; if ({busy, done} !== 2'b00 || result !== 32'h6) begin errors++; $display("FAIL flush_with_dout: got %b %h want 00 00000006", {busy, done}, result); end
    endtask

    task automatic test_flush_mul_send();
        int hs0 = hs_s;
        issue(7'h01, 32'h3, 32'h5);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL flush_mul: got %b want 00", {busy, done}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_mul_done%0d: got %b want 0", i, done); end
        end
        issue(7'h08, 32'h9, 32'h3);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if ({busy, div_s_valid} !== 2'b00) begin errors++; $display("FAIL flush_send: got %b want 00", {busy, div_s_valid}); end
        div_s_ready = 1'b1; tick(); tick(); div_s_ready = 1'b0;
        checks++; if ((hs_s - hs0) !== 0 || done !== 1'b0) begin errors++; $display("FAIL flush_send_hs: got hs=%0d done=%b want 0 0", hs_s - hs0, done); end
    endtask

    task automatic test_reset_mid();
        issue(7'h08, 32'h9, 32'h3);
        div_s_ready = 1'b1; tick(); div_s_ready = 1'b0;
        tick();
        resetn = 1'b0; tick(); resetn = 1'b1;
        checks++; if ({busy, done, div_s_valid, div_u_valid, mul_signed} !== 5'b0 || result !== 32'h0) begin errors++; $display("FAIL midreset_ctrl: got %b %h want 00000 0", {busy, done, div_s_valid, div_u_valid, mul_signed}, result); end
        checks++; if ({mul_x, div_dividend} !== 65'h0) begin errors++; $display("FAIL midreset_ops: got %h want 0", {mul_x, div_dividend}); end
        div_s_dout_valid = 1'b1; div_s_dout = 64'h00000003_00000000;
        tick();
        div_s_dout_valid = 1'b0;
        checks++; if ({busy, done} !== 2'b00 || result !== 32'h0) begin errors++; $display("FAIL midreset_stale: got %b %h want 00 0", {busy, done}, result); end
        issue(7'h01, 32'h3, 32'h5);
        tick(); tick();
        checks++; if (done !== 1'b1 || result !== 32'hF) begin errors++; $display("FAIL midreset_mul: got done=%b %h want 1 0000000f", done, result); end
        take();
    endtask

    initial begin
        tick();
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush_div();
        test_flush_mul_send();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
